systolic_pe_ws: RTL and testbench
=================================

Name: systolic_pe_ws

Overview:
Parametrised weight-stationary processing element for the systolic matrix-multiply array. Activations flow west→east and partial sums flow north→south, each registered once per PE. Adds over the previous-generation PE: valid qualification, a double-buffered weight register loaded by a column shift chain, a travelling weight-swap wave, signed/unsigned activations, and saturating accumulation with a sticky overflow flag.

Parameters:
ACT_W, 8, activation width
WGT_W, 8, weight width (always signed)
PSUM_W, 32, partial-sum width (signed)
ACT_SIGNED, 0, 1 = activation two's complement; 0 = unsigned, zero-extended
SATURATE, 1, 1 = clamp psum on overflow; 0 = two's-complement wrap

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
act_in  in  ACT_W  activation from west
act_valid_in  in  1  act_in qualifier
psum_in  in  PSUM_W  partial sum from north
psum_valid_in  in  1  psum_in qualifier (tied 0 on the top row)
wgt_in  in  WGT_W  weight shift-chain input from north
wgt_load_in  in  1  shift-chain enable
wgt_swap_in  in  1  commit shadow→active request
clr_ovf  in  1  clear sticky overflow
act_out  out  ACT_W  registered activation to east
act_valid_out  out  1  registered qualifier
psum_out  out  PSUM_W  registered partial sum to south
psum_valid_out  out  1  registered qualifier
wgt_out  out  WGT_W  shadow-register value to the PE below
wgt_load_out  out  1  registered wgt_load_in
wgt_swap_out  out  1  registered wgt_swap_in, to east
ovf_flag  out  1  sticky overflow indicator

Behaviour:
- Reset (reset_n=0 at posedge): every output register, shadow weight, and active weight → 0. Reset mid-load or mid-stream discards all state. No output is X after the first reset edge.
- Weight shadow: on wgt_load_in=1, shadow ← wgt_in. wgt_out = shadow, driven directly from the register. A column of N PEs is loaded in N cycles, bottom-row weight first. wgt_load_out ← wgt_load_in with 1-cycle latency.
- Swap: on wgt_swap_in=1, active ← shadow, using the pre-edge shadow value even if wgt_load_in=1 in the same cycle. wgt_swap_out ← wgt_swap_in with 1-cycle latency.
- Active weight is unchanged by loading; a MAC in the swap cycle uses the old active weight, and the new weight is effective from the next cycle.
- Datapath, all updates registered at posedge, latency 1:
  - act_valid_in=1: act_out ← act_in; act_valid_out ← 1; psum_out ← f(P + A×W); psum_valid_out ← 1.
    - P = psum_in if psum_valid_in, else 0.
    - A = act_in, sign- or zero-extended per ACT_SIGNED.
    - W = active weight.
  - act_valid_in=0, psum_valid_in=1 (bypass): psum_out ← psum_in unmodified; psum_valid_out ← 1; act_out holds; act_valid_out ← 0.
  - Both valids 0: act_out and psum_out hold value; both valid_outs ← 0.
- Arithmetic widths:
  - Product: ACT_W+WGT_W+1 bits, signed.
  - Sum: computed at PSUM_W+1 bits, sign-extended.
  - Overflow: sum outside [−2^(PSUM_W−1), 2^(PSUM_W−1)−1].
  - SATURATE=1: clamp to the nearest bound.
  - SATURATE=0: keep the low PSUM_W bits.
- ovf_flag is set on any overflow in either mode; overflow is evaluated only in MAC cycles. clr_ovf clears the flag. If clr_ovf and a new overflow occur in the same cycle, the flag ends at 1 (set wins).

Test Plan:
1. Reset/idle: assert reset_n=0 for 2 cycles with random inputs → all outputs 0; release with valids 0 → outputs stay 0.
2. Load and swap: shift wgt_in=5 with load=1, then pulse swap → wgt_out=5, wgt_load_out and wgt_swap_out each delayed 1 cycle. Then act_in=3, psum_in=10, both valid → next cycle psum_out=25, act_out=3.
3. Swap during stream: active weight=2, shadow=−4. Drive act_in=7 with psum_valid=0 on 3 consecutive cycles, swap asserted in cycle 1 → psum_out sequence 14, 14, −28.
4. Bypass and hold: act_valid=0, psum_valid=1, psum_in=1234 → psum_out=1234, act_valid_out=0, act_out unchanged. Next cycle with both valids 0 → psum_out holds 1234, psum_valid_out=0.
5. Saturation, SATURATE=1: psum_in=2^31−100, act=255, W=127 → psum_out=0x7FFFFFFF, ovf_flag=1. Pulse clr_ovf while another overflow occurs → flag stays 1.
6. Wrap and signed mode, SATURATE=0, ACT_SIGNED=1: act_in=0x80 (−128), W=−128, psum_in=0 → psum_out=16384, no overflow. Then psum_in=0x7FFFFFFF → wrapped result 0x80003FFF, ovf_flag=1.

Source files
------------

// File: rtl/systolic_pe_ws.sv
// Weight-stationary systolic PE: registered act (W->E) and psum (N->S) paths,
// double-buffered weight with shift-chain load and travelling swap wave.
module systolic_pe_ws #(
    parameter int ACT_W      = 8,
    parameter int WGT_W      = 8,
    parameter int PSUM_W     = 32,
    parameter int ACT_SIGNED = 0,
    parameter int SATURATE   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ACT_W-1:0]  act_in,
    input  logic              act_valid_in,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_valid_in,
    input  logic [WGT_W-1:0]  wgt_in,
    input  logic              wgt_load_in,
    input  logic              wgt_swap_in,
    input  logic              clr_ovf,
    output logic [ACT_W-1:0]  act_out,
    output logic              act_valid_out,
    output logic [PSUM_W-1:0] psum_out,
    output logic              psum_valid_out,
    output logic [WGT_W-1:0]  wgt_out,
    output logic              wgt_load_out,
    output logic              wgt_swap_out,
    output logic              ovf_flag
);
    localparam int PROD_W = ACT_W + WGT_W + 1;

    logic [ACT_W-1:0]  act_q, act_d;
    logic              act_valid_q, act_valid_d;
    logic [PSUM_W-1:0] psum_q, psum_d;
    logic              psum_valid_q, psum_valid_d;
    logic [WGT_W-1:0]  wgt_sh_q, wgt_sh_d;
    logic [WGT_W-1:0]  wgt_act_q, wgt_act_d;
    logic              wgt_load_q, wgt_swap_q;
    logic              ovf_q, ovf_d;

    logic [PROD_W-1:0] a_ext, w_ext, prod;
    logic [PSUM_W-1:0] p_sel;
    logic [PSUM_W:0]   sum;
    logic              ovf;
    logic [PSUM_W-1:0] mac_res;

    // Both operands are pre-extended to the product width so the truncated
    // multiply yields the exact signed product.
    always_comb begin
        if (ACT_SIGNED != 0) a_ext = {{(WGT_W+1){act_in[ACT_W-1]}}, act_in};
        else                 a_ext = {{(WGT_W+1){1'b0}}, act_in};
        w_ext = {{(ACT_W+1){wgt_act_q[WGT_W-1]}}, wgt_act_q};
        prod  = a_ext * w_ext;
        p_sel = psum_valid_in ? psum_in : '0;
        sum   = {p_sel[PSUM_W-1], p_sel} + {{(PSUM_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        ovf   = sum[PSUM_W] != sum[PSUM_W-1];
        mac_res = sum[PSUM_W-1:0];
        if (ovf && SATURATE != 0)
            mac_res = sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    end

    always_comb begin
        act_d        = act_q;
        act_valid_d  = 1'b0;
        psum_d       = psum_q;
        psum_valid_d = 1'b0;
        wgt_sh_d     = wgt_load_in ? wgt_in : wgt_sh_q;
        wgt_act_d    = wgt_swap_in ? wgt_sh_q : wgt_act_q;
        ovf_d        = clr_ovf ? 1'b0 : ovf_q;
        if (act_valid_in) begin
            act_d        = act_in;
            act_valid_d  = 1'b1;
            psum_d       = mac_res;
            psum_valid_d = 1'b1;
            if (ovf) ovf_d = 1'b1;
        end else if (psum_valid_in) begin
            psum_d       = psum_in;
            psum_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            wgt_sh_q     <= '0;
            wgt_act_q    <= '0;
            wgt_load_q   <= 1'b0;
            wgt_swap_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            act_q        <= act_d;
            act_valid_q  <= act_valid_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            wgt_sh_q     <= wgt_sh_d;
            wgt_act_q    <= wgt_act_d;
            wgt_load_q   <= wgt_load_in;
            wgt_swap_q   <= wgt_swap_in;
            ovf_q        <= ovf_d;
        end
    end

    assign act_out        = act_q;
    assign act_valid_out  = act_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign wgt_out        = wgt_sh_q;
    assign wgt_load_out   = wgt_load_q;
    assign wgt_swap_out   = wgt_swap_q;
    assign ovf_flag       = ovf_q;
endmodule

// File: tb/tb_systolic_pe_ws.sv
// Directed bench for systolic_pe_ws: default instance (unsigned, saturating)
// and a signed/wrapping instance sharing the same stimulus.
module tb_systolic_pe_ws;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  act_in;
    logic        act_valid_in;
    logic [31:0] psum_in;
    logic        psum_valid_in;
    logic [7:0]  wgt_in;
    logic        wgt_load_in;
    logic        wgt_swap_in;
    logic        clr_ovf;

    logic [7:0]  act_out_1, wgt_out_1, act_out_2, wgt_out_2;
    logic [31:0] psum_out_1, psum_out_2;
    logic        act_valid_out_1, psum_valid_out_1, wgt_load_out_1, wgt_swap_out_1, ovf_flag_1;
    logic        act_valid_out_2, psum_valid_out_2, wgt_load_out_2, wgt_swap_out_2, ovf_flag_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_pe_ws u_dut_sat (
        .clk(clk), .reset_n(reset_n),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .wgt_in(wgt_in), .wgt_load_in(wgt_load_in), .wgt_swap_in(wgt_swap_in),
        .clr_ovf(clr_ovf),
        .act_out(act_out_1), .act_valid_out(act_valid_out_1),
        .psum_out(psum_out_1), .psum_valid_out(psum_valid_out_1),
        .wgt_out(wgt_out_1), .wgt_load_out(wgt_load_out_1),
        .wgt_swap_out(wgt_swap_out_1), .ovf_flag(ovf_flag_1)
    );

    systolic_pe_ws #(.ACT_SIGNED(1), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .act_in(act_in), .act_valid_in(act_valid_in),
        .psum_in(psum_in), .psum_valid_in(psum_valid_in),
        .wgt_in(wgt_in), .wgt_load_in(wgt_load_in), .wgt_swap_in(wgt_swap_in),
        .clr_ovf(clr_ovf),
        .act_out(act_out_2), .act_valid_out(act_valid_out_2),
        .psum_out(psum_out_2), .psum_valid_out(psum_valid_out_2),
        .wgt_out(wgt_out_2), .wgt_load_out(wgt_load_out_2),
        .wgt_swap_out(wgt_swap_out_2), .ovf_flag(ovf_flag_2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        act_valid_in = 1'b0; psum_valid_in = 1'b0;
        wgt_load_in = 1'b0; wgt_swap_in = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psum1"}, {32'd0, psum_out_1}, 64'd0);
        check({tag, "_psum2"}, {32'd0, psum_out_2}, 64'd0);
        check({tag, "_misc1"}, {act_out_1, wgt_out_1, act_valid_out_1, psum_valid_out_1,
                                wgt_load_out_1, wgt_swap_out_1, ovf_flag_1}, 64'd0);
        check({tag, "_misc2"}, {act_out_2, wgt_out_2, act_valid_out_2, psum_valid_out_2,
                                wgt_load_out_2, wgt_swap_out_2, ovf_flag_2}, 64'd0);
    endtask

    initial begin
        // 1. reset with random inputs, then idle
        #1;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act_in = 8'($urandom); psum_in = $urandom; wgt_in = 8'($urandom);
            act_valid_in = 1'b1; psum_valid_in = 1'b1; wgt_load_in = 1'b1;
            wgt_swap_in = 1'b1; clr_ovf = 1'($urandom);
            step();
        end
        check_all_zero("reset");
        reset_n = 1'b1; idle();
        step(); step();
        check_all_zero("idle");

        // 2. load 5, swap, MAC 10 + 3*5
        wgt_in = 8'd5; wgt_load_in = 1'b1;
        step();
        check("ld_wgt_out", {56'd0, wgt_out_1}, 64'd5);
        check("ld_load_out", {63'd0, wgt_load_out_1}, 64'd1);
        check("ld_swap_out", {63'd0, wgt_swap_out_1}, 64'd0);
        wgt_load_in = 1'b0; wgt_swap_in = 1'b1;
        step();
        check("sw_load_out", {63'd0, wgt_load_out_1}, 64'd0);
        check("sw_swap_out", {63'd0, wgt_swap_out_1}, 64'd1);
        check("sw_wgt_out", {56'd0, wgt_out_1}, 64'd5);
        wgt_swap_in = 1'b0;
        act_in = 8'd3; act_valid_in = 1'b1; psum_in = 32'd10; psum_valid_in = 1'b1;
        step();
        check("mac_psum", {32'd0, psum_out_1}, 64'd25);
        check("mac_act", {56'd0, act_out_1}, 64'd3);
        check("mac_valids", {62'd0, act_valid_out_1, psum_valid_out_1}, 64'd3);
        check("mac_swap_out", {63'd0, wgt_swap_out_1}, 64'd0);

        // 3. active=2, shadow=-4 (swap coincides with load of -4), stream act 7
        idle();
        wgt_in = 8'd2; wgt_load_in = 1'b1;
        step();
        wgt_in = 8'hFC; wgt_swap_in = 1'b1;
        step();
        check("shadow_m4", {56'd0, wgt_out_1}, 64'hFC);
        idle();
        act_in = 8'd7; act_valid_in = 1'b1;
        step();
        check("strm0", {32'd0, psum_out_1}, 64'd14);
        wgt_swap_in = 1'b1;
        step();
        check("strm1", {32'd0, psum_out_1}, 64'd14);
        wgt_swap_in = 1'b0;
        step();
        check("strm2", {32'd0, psum_out_1}, 64'hFFFF_FFE4);

        // 4. bypass then hold
        idle();
        psum_in = 32'd1234; psum_valid_in = 1'b1;
        step();
        check("byp_psum", {32'd0, psum_out_1}, 64'd1234);
        check("byp_valids", {62'd0, act_valid_out_1, psum_valid_out_1}, 64'd1);
        check("byp_act", {56'd0, act_out_1}, 64'd7);
        psum_valid_in = 1'b0;
        step();
        check("hold_psum", {32'd0, psum_out_1}, 64'd1234);
        check("hold_valids", {62'd0, act_valid_out_1, psum_valid_out_1}, 64'd0);
        check("hold_act", {56'd0, act_out_1}, 64'd7);
        check("pre_ovf1", {63'd0, ovf_flag_1}, 64'd0);

        // 5. saturation and set-wins-over-clear
        wgt_in = 8'd127; wgt_load_in = 1'b1;
        step();
        wgt_load_in = 1'b0; wgt_swap_in = 1'b1;
        step();
        wgt_swap_in = 1'b0;
        act_in = 8'd255; act_valid_in = 1'b1;
        psum_in = 32'h7FFF_FF9C; psum_valid_in = 1'b1;
        step();
        check("sat_psum", {32'd0, psum_out_1}, 64'h7FFF_FFFF);
        check("sat_ovf", {63'd0, ovf_flag_1}, 64'd1);
        idle(); clr_ovf = 1'b1;
        step();
        check("clr_ovf", {63'd0, ovf_flag_1}, 64'd0);
        step();
        clr_ovf = 1'b1; act_valid_in = 1'b1; psum_valid_in = 1'b1;
        step();
        check("set_wins", {63'd0, ovf_flag_1}, 64'd1);
        check("sat_psum2", {32'd0, psum_out_1}, 64'h7FFF_FFFF);

        // 6. signed/wrap instance: -128 * -128, then wrap past max
        idle();
        wgt_in = 8'h80; wgt_load_in = 1'b1;
        step();
        wgt_load_in = 1'b0; wgt_swap_in = 1'b1;
        step();
        wgt_swap_in = 1'b0; clr_ovf = 1'b1;
        act_in = 8'h80; act_valid_in = 1'b1; psum_in = 32'd0; psum_valid_in = 1'b1;
        step();
        check("sgn_psum", {32'd0, psum_out_2}, 64'd16384);
        check("sgn_ovf", {63'd0, ovf_flag_2}, 64'd0);
        check("uns_psum", {32'd0, psum_out_1}, 64'hFFFF_C000);
        clr_ovf = 1'b0; psum_in = 32'h7FFF_FFFF;
        step();
        check("wrap_psum", {32'd0, psum_out_2}, 64'h8000_3FFF);
        check("wrap_ovf", {63'd0, ovf_flag_2}, 64'd1);

        // mid-stream reset discards weights and flags
        reset_n = 1'b0;
        step();
        check_all_zero("rst2");
        reset_n = 1'b1; idle();
        act_in = 8'd9; act_valid_in = 1'b1; psum_in = 32'd0; psum_valid_in = 1'b1;
        step();
        check("rst2_wgt0", {32'd0, psum_out_1}, 64'd0);
        check("rst2_act", {56'd0, act_out_1}, 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
